// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Frame layout: two count bytes, 4*N payload bytes, one checksum byte.
  localparam int unsigned HDR_LEN        = 2;
  localparam int unsigned CSUM_LEN       = 1;
  localparam int unsigned BYTES_PER_WORD = 4;

  localparam int unsigned DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word/word_complete are combinational so the caller can register the
// write on the same edge that accepts the final byte of a word.
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane;
  logic [23:0] asm_q;

  assign word_complete = byte_en && (lane == LAST_LANE);
  assign word          = {byte_in, asm_q};

  // Lane counter and lower three bytes of the word being assembled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= '0;
      asm_q <= '0;
    end else if (byte_en) begin
      unique case (lane)
        2'd0:    asm_q[7:0]   <= byte_in;
        2'd1:    asm_q[15:8]  <= byte_in;
        2'd2:    asm_q[23:16] <= byte_in;
        default: asm_q        <= asm_q;
      endcase
      lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader that writes the instruction memory and holds
// the core in reset until a complete image with a good checksum is loaded.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = DEFAULT_MAX_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [15:0] MAX_W = MAX_WORDS[15:0];

  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [7:0]  csum;

  logic        xfer;
  logic        start_ok;
  logic        pack_en;
  logic [15:0] hdr_count;
  logic [31:0] packed_word;
  logic        word_complete;

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign pack_en   = xfer && (state == DATA);
  assign hdr_count = {in_data, count[7:0]};

  imem_boot_loader_byte_word_packer u_byte_word_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .byte_en       (pack_en),
    .byte_in       (in_data),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  // Frame FSM with registered outputs; reset takes priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      word_idx   <= '0;
      csum       <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR0;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
            word_idx   <= '0;
            csum       <= '0;
          end
        end
        HDR0: begin
          if (xfer) begin
            count[7:0] <= in_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            count[15:8] <= in_data;
            if ((hdr_count == 16'd0) || (hdr_count > MAX_W)) begin
              state    <= ERR;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ in_data;
            if (word_complete) begin
              imem_we    <= 1'b1;
              imem_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
              imem_wdata <= packed_word;
              word_idx   <= word_idx + 16'd1;
              if (word_idx == count - 16'd1) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: per-cycle vector table plus
// hand-written multi-cycle sequences checked against a write log.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  imem_boot_loader #(.ADDR_WIDTH(32), .MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag bundle order: {in_ready, imem_we, core_reset, busy, done, error}
  localparam logic [5:0] F_RST  = 6'b001000;
  localparam logic [5:0] F_BUSY = 6'b101100;
  localparam logic [5:0] F_WR   = 6'b111100;
  localparam logic [5:0] F_DONE = 6'b000010;
  localparam logic [5:0] F_ERR  = 6'b001001;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [5:0]  exp_flags;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        tbl [13];
  wr_t         wq [$];
  logic [31:0] img [4];
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_we = 1'b0;
  logic        long_strobe = 1'b0;

  function automatic logic [5:0] flags();
    return {in_ready, imem_we, core_reset, busy, done, error};
  endfunction

  function automatic logic [7:0] img_csum(input int n);
    logic [7:0] c = 8'h00;
    for (int w = 0; w < n; w++)
      c = c ^ img[w][7:0] ^ img[w][15:8] ^ img[w][23:16] ^ img[w][31:24];
    return c;
  endfunction

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back('{addr: imem_addr, data: imem_wdata});
      if (prev_we) long_strobe = 1'b1;
    end
    prev_we = imem_we;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) step();
    in_valid = 1'b1; in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int maxgap);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++)
        send_byte(img[w][8*b +: 8], maxgap);
  endtask

  task automatic chk_writes(input string name, input int n);
    chk({name, " nwr"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk({name, " addr"}, 64'(wq[i].addr), 64'(4 * i));
      chk({name, " data"}, 64'(wq[i].data), 64'(img[i]));
    end
  endtask

  initial begin
    // Per-cycle vectors for a 2-word load; payload XOR is 0x31.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, F_BUSY, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 8'h02, F_BUSY, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, F_BUSY, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 8'h13, F_BUSY, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, F_BUSY, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, F_BUSY, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, F_WR,   32'h0, 32'h00000013};
    tbl[7]  = '{1'b0, 1'b1, 8'hEF, F_BUSY, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 8'hBE, F_BUSY, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 8'hAD, F_BUSY, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 8'hDE, F_WR,   32'h4, 32'hDEADBEEF};
    tbl[11] = '{1'b0, 1'b1, 8'h31, F_DONE, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, F_DONE, 32'h0, 32'h0};

    // Reset values
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    chk("reset flags", 64'(flags()), 64'(F_RST));
    chk("reset addr", 64'(imem_addr), 64'h0);
    chk("reset wdata", 64'(imem_wdata), 64'h0);
    reset = 1'b0;

    // Table-driven nominal load
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; in_valid = tbl[i].valid; in_data = tbl[i].data;
      step();
      chk($sformatf("vec%0d flags", i), 64'(flags()), 64'(tbl[i].exp_flags));
      if (tbl[i].exp_flags[4]) begin
        chk($sformatf("vec%0d addr", i), 64'(imem_addr), 64'(tbl[i].exp_addr));
        chk($sformatf("vec%0d wdata", i), 64'(imem_wdata), 64'(tbl[i].exp_wdata));
      end
    end
    start = 1'b0; in_valid = 1'b0;

    // Bad checksum: both words written, then ERR with core held
    img[0] = 32'h00000013; img[1] = 32'hDEADBEEF;
    wq.delete();
    start_pulse();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_words(2, 0);
    send_byte(8'h00, 0);
    chk("badcsum flags", 64'(flags()), 64'(F_ERR));
    chk_writes("badcsum", 2);
    step(); step(); step();
    chk("badcsum hold", 64'(flags()), 64'(F_ERR));
    chk("badcsum nwr late", 64'(wq.size()), 64'd2);

    // Header bounds: N=0 and N=257 rejected, N=256 accepted
    wq.delete();
    start_pulse();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("n0 flags", 64'(flags()), 64'(F_ERR));
    start_pulse();
    chk("restart from err", 64'(flags()), 64'(F_BUSY));
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    chk("n257 flags", 64'(flags()), 64'(F_ERR));
    start_pulse();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    chk("n256 flags", 64'(flags()), 64'(F_BUSY));
    do_reset();
    chk("hdr nwr", 64'(wq.size()), 64'd0);

    // Random valid gaps through a 4-word image
    img[0] = 32'h11223344; img[1] = 32'hA5A55A5A;
    img[2] = 32'h0000FFFF; img[3] = 32'h8badf00d;
    wq.delete(); long_strobe = 1'b0;
    start_pulse();
    send_byte(8'h04, 5); send_byte(8'h00, 5);
    send_words(4, 5);
    send_byte(img_csum(4), 5);
    chk("gaps flags", 64'(flags()), 64'(F_DONE));
    chk_writes("gaps", 4);
    chk("gaps strobe", 64'(long_strobe), 64'd0);

    // Reset mid-frame, coinciding with the lane-3 byte of word 1
    img[0] = 32'h00000013; img[1] = 32'hDEADBEEF;
    wq.delete();
    start_pulse();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_words(1, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hDE;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst flags", 64'(flags()), 64'(F_RST));
    chk("midrst addr", 64'(imem_addr), 64'h0);
    chk("midrst wdata", 64'(imem_wdata), 64'h0);
    step(); step();
    chk_writes("midrst", 1);
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    chk("rst beats start", 64'(flags()), 64'(F_RST));
    wq.delete();
    start_pulse();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_words(2, 0);
    send_byte(img_csum(2), 0);
    chk("reload flags", 64'(flags()), 64'(F_DONE));
    chk_writes("reload", 2);

    // start ignored in DATA; start on DONE transition not seen; start in DONE reloads
    img[0] = 32'h12345678;
    wq.delete();
    start_pulse();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0);
    start_pulse();
    chk("start in data", 64'(flags()), 64'(F_BUSY));
    start = 1'b1; send_byte(8'h34, 0); start = 1'b0;
    send_byte(8'h12, 0);
    start = 1'b1; send_byte(img_csum(1), 0); start = 1'b0;
    chk("done w/ start", 64'(flags()), 64'(F_DONE));
    step();
    chk("start at done edge", 64'(flags()), 64'(F_DONE));
    chk_writes("ignstart", 1);
    start_pulse();
    chk("start in done", 64'(flags()), 64'(F_BUSY));
    img[0] = 32'hCAFEF00D;
    wq.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_words(1, 0);
    send_byte(img_csum(1), 0);
    chk("second img flags", 64'(flags()), 64'(F_DONE));
    chk_writes("second img", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
